// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: clears its word memory after reset, then serves
// loads, stores and pass-through beats with a one-cycle registered write-back.
module mem_access_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_value,
    input  logic [REG_W-1:0]  in_reg,
    input  logic              in_is_load,
    input  logic              in_is_mem_write,
    input  logic              in_is_write,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg,
    output logic              wb_we,
    output logic [CNT_W-1:0]  stat_loads,
    output logic [CNT_W-1:0]  stat_stores,
    output logic              init_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, next_state;
    logic [ADDR_W-1:0]  init_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        init_done  = 1'b0;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = in_addr;
        mem_wdata  = in_value;
        case (state)
            INIT: begin
                mem_we    = rst_n;
                mem_waddr = init_ptr;
                mem_wdata = '0;
                if (init_ptr == {ADDR_W{1'b1}})
                    next_state = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                in_ready  = !wb_valid || wb_ready;
                accept    = in_valid && in_ready;
                mem_we    = rst_n && accept && in_is_mem_write;
            end
            default: next_state = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == INIT)
                init_ptr <= init_ptr + 1'b1;
        end
    end

    // NOTE: the memory array has no reset; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Loads read mem here with the pre-edge value, so a same-edge store is not visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_reg      <= '0;
            wb_we       <= 1'b0;
            stat_loads  <= '0;
            stat_stores <= '0;
        end else if (accept && in_is_mem_write) begin
            stat_stores <= stat_stores + 1'b1;
            if (wb_ready)
                wb_valid <= 1'b0;
        end else if (accept) begin
            wb_valid <= 1'b1;
            wb_data  <= in_is_load ? mem[in_addr] : in_value;
            wb_reg   <= in_reg;
            wb_we    <= in_is_write;
            if (in_is_load)
                stat_loads <= stat_loads + 1'b1;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule
